// File: rtl/tl_async_pkg.sv
// Shared beat layouts and defaults for the TileLink-UL async crossing.
// Latency: n/a (types only).
// Backpressure: n/a.
package tl_async_pkg;

    localparam int SYNC_STAGES_DEFAULT = 3;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic        source;
        logic [8:0]  address;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } a_bits_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [1:0]  size;
        logic        source;
        logic        sink;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } d_bits_t;

endpackage

// File: rtl/tl_async_sync_reg.sv
// Reset-to-zero flop chain used to bring remote-domain flags into the local clock.
// Latency: DEPTH cycles from d to q.
// Backpressure: none; samples every cycle.
module tl_async_sync_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/tl_async_crossing_source.sv
// Master-side half of a depth-1 TL-UL async crossing: exports A beats, imports D beats.
// Latency: A ready returns SYNC_STAGES after remote ridx; D valid SYNC_STAGES+1 after remote widx.
// Backpressure: one beat in flight per channel; valid/bits held until ready.
module tl_async_crossing_source
    import tl_async_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        auto_in_a_valid,
    output logic        auto_in_a_ready,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [1:0]  auto_in_a_bits_size,
    input  logic        auto_in_a_bits_source,
    input  logic [8:0]  auto_in_a_bits_address,
    input  logic [3:0]  auto_in_a_bits_mask,
    input  logic [31:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,

    output logic        auto_in_d_valid,
    input  logic        auto_in_d_ready,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [1:0]  auto_in_d_bits_size,
    output logic        auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [31:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt,

    output logic [2:0]  auto_out_a_mem_0_opcode,
    output logic [2:0]  auto_out_a_mem_0_param,
    output logic [1:0]  auto_out_a_mem_0_size,
    output logic        auto_out_a_mem_0_source,
    output logic [8:0]  auto_out_a_mem_0_address,
    output logic [3:0]  auto_out_a_mem_0_mask,
    output logic [31:0] auto_out_a_mem_0_data,
    output logic        auto_out_a_mem_0_corrupt,
    output logic        auto_out_a_widx,
    output logic        auto_out_a_safe_widx_valid,
    output logic        auto_out_a_safe_source_reset_n,
    input  logic        auto_out_a_ridx,
    input  logic        auto_out_a_safe_ridx_valid,
    input  logic        auto_out_a_safe_sink_reset_n,

    input  logic [2:0]  auto_out_d_mem_0_opcode,
    input  logic [1:0]  auto_out_d_mem_0_param,
    input  logic [1:0]  auto_out_d_mem_0_size,
    input  logic        auto_out_d_mem_0_source,
    input  logic        auto_out_d_mem_0_sink,
    input  logic        auto_out_d_mem_0_denied,
    input  logic [31:0] auto_out_d_mem_0_data,
    input  logic        auto_out_d_mem_0_corrupt,
    input  logic        auto_out_d_widx,
    input  logic        auto_out_d_safe_widx_valid,
    input  logic        auto_out_d_safe_source_reset_n,
    output logic        auto_out_d_ridx,
    output logic        auto_out_d_safe_ridx_valid,
    output logic        auto_out_d_safe_sink_reset_n
);

    a_bits_t a_in;
    a_bits_t a_mem;
    d_bits_t d_mem;
    d_bits_t d_bits_q;

    logic alive;
    logic a_widx;
    logic a_ridx_s;
    logic a_peer_ok;
    logic a_sink_rst_s;
    logic a_kill;
    logic a_ready;
    logic a_fire;

    logic d_ridx;
    logic d_widx_s;
    logic d_peer_ok;
    logic d_src_rst_s;
    logic d_kill;
    logic d_pending;
    logic d_valid_q;
    logic d_fire;

    assign a_in = '{
        opcode:  auto_in_a_bits_opcode,
        param:   auto_in_a_bits_param,
        size:    auto_in_a_bits_size,
        source:  auto_in_a_bits_source,
        address: auto_in_a_bits_address,
        mask:    auto_in_a_bits_mask,
        data:    auto_in_a_bits_data,
        corrupt: auto_in_a_bits_corrupt
    };

    assign d_mem = '{
        opcode:  auto_out_d_mem_0_opcode,
        param:   auto_out_d_mem_0_param,
        size:    auto_out_d_mem_0_size,
        source:  auto_out_d_mem_0_source,
        sink:    auto_out_d_mem_0_sink,
        denied:  auto_out_d_mem_0_denied,
        data:    auto_out_d_mem_0_data,
        corrupt: auto_out_d_mem_0_corrupt
    };

    always_ff @(posedge clock) begin
        if (!reset) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    // ---------------- A channel ----------------
    tl_async_sync_reg #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_a_ridx_sync (
        .clock (clock),
        .reset (reset),
        .d     (auto_out_a_ridx),
        .q     (a_ridx_s)
    );

    tl_async_sync_reg #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_a_peer_sync (
        .clock (clock),
        .reset (reset),
        .d     (auto_out_a_safe_ridx_valid & auto_out_a_safe_sink_reset_n),
        .q     (a_peer_ok)
    );

    tl_async_sync_reg #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_a_rst_sync (
        .clock (clock),
        .reset (reset),
        .d     (auto_out_a_safe_sink_reset_n),
        .q     (a_sink_rst_s)
    );

    assign a_kill  = !reset || !a_sink_rst_s;
    // Slot is free once the remote read index has caught up with ours.
    assign a_ready = a_peer_ok && (a_widx == a_ridx_s) && !a_kill;
    assign a_fire  = auto_in_a_valid && a_ready;

    always_ff @(posedge clock) begin
        if (a_kill)      a_widx <= 1'b0;
        else if (a_fire) a_widx <= ~a_widx;
    end

    // Exported entry survives a remote kill; only local reset clears it.
    always_ff @(posedge clock) begin
        if (!reset)      a_mem <= '0;
        else if (a_fire) a_mem <= a_in;
    end

    // ---------------- D channel ----------------
    tl_async_sync_reg #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_d_widx_sync (
        .clock (clock),
        .reset (reset),
        .d     (auto_out_d_widx),
        .q     (d_widx_s)
    );

    tl_async_sync_reg #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_d_peer_sync (
        .clock (clock),
        .reset (reset),
        .d     (auto_out_d_safe_widx_valid & auto_out_d_safe_source_reset_n),
        .q     (d_peer_ok)
    );

    tl_async_sync_reg #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_d_rst_sync (
        .clock (clock),
        .reset (reset),
        .d     (auto_out_d_safe_source_reset_n),
        .q     (d_src_rst_s)
    );

    assign d_kill    = !reset || !d_src_rst_s;
    assign d_pending = d_peer_ok && (d_widx_s != d_ridx);
    assign d_fire    = d_valid_q && auto_in_d_ready;

    always_ff @(posedge clock) begin
        if (d_kill) begin
            d_ridx    <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            d_valid_q <= d_pending && !d_fire;
            if (d_fire) d_ridx <= ~d_ridx;
        end
    end

    // Capture only on the rising edge of valid so bits stay frozen while stalled.
    always_ff @(posedge clock) begin
        if (!reset)                       d_bits_q <= '0;
        else if (d_pending && !d_valid_q) d_bits_q <= d_mem;
    end

    // ---------------- outputs ----------------
    assign auto_in_a_ready                = a_ready;
    assign auto_out_a_widx                = a_widx;
    assign auto_out_a_safe_widx_valid     = alive;
    assign auto_out_a_safe_source_reset_n = alive;

    assign auto_out_a_mem_0_opcode        = a_mem.opcode;
    assign auto_out_a_mem_0_param         = a_mem.param;
    assign auto_out_a_mem_0_size          = a_mem.size;
    assign auto_out_a_mem_0_source        = a_mem.source;
    assign auto_out_a_mem_0_address       = a_mem.address;
    assign auto_out_a_mem_0_mask          = a_mem.mask;
    assign auto_out_a_mem_0_data          = a_mem.data;
    assign auto_out_a_mem_0_corrupt       = a_mem.corrupt;

    assign auto_in_d_valid                = d_valid_q;
    assign auto_in_d_bits_opcode          = d_bits_q.opcode;
    assign auto_in_d_bits_param           = d_bits_q.param;
    assign auto_in_d_bits_size            = d_bits_q.size;
    assign auto_in_d_bits_source          = d_bits_q.source;
    assign auto_in_d_bits_sink            = d_bits_q.sink;
    assign auto_in_d_bits_denied          = d_bits_q.denied;
    assign auto_in_d_bits_data            = d_bits_q.data;
    assign auto_in_d_bits_corrupt         = d_bits_q.corrupt;

    assign auto_out_d_ridx                = d_ridx;
    assign auto_out_d_safe_ridx_valid     = alive;
    assign auto_out_d_safe_sink_reset_n   = alive;

endmodule

// File: tb/tb_tl_async_crossing_source.sv
// Directed bench for tl_async_crossing_source: drives and samples on the falling edge.
module tb_tl_async_crossing_source;
    import tl_async_pkg::*;

    localparam int SS = 3;

    logic        clock = 1'b0;
    logic        reset;

    logic        a_valid, a_ready;
    a_bits_t     a_drv;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param, d_size;
    logic        d_source, d_sink, d_denied, d_corrupt;
    logic [31:0] d_data;

    logic [2:0]  m_opcode, m_param;
    logic [1:0]  m_size;
    logic        m_source, m_corrupt;
    logic [8:0]  m_address;
    logic [3:0]  m_mask;
    logic [31:0] m_data;
    logic        a_widx, a_safe_widx_valid, a_safe_source_reset_n;
    logic        a_ridx, a_safe_ridx_valid, a_safe_sink_reset_n;

    d_bits_t     d_rem;
    logic        d_widx, d_safe_widx_valid, d_safe_source_reset_n;
    logic        d_ridx, d_safe_ridx_valid, d_safe_sink_reset_n;

    int vectors = 0;
    int miscompares = 0;

    a_bits_t beat1, beat2, beat3, beat4, a_obs;
    d_bits_t dbeat1, dbeat2, dbeat3, d_obs;

    always #5 clock = ~clock;

    tl_async_crossing_source #(.SYNC_STAGES(SS)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .auto_in_a_valid                (a_valid),
        .auto_in_a_ready                (a_ready),
        .auto_in_a_bits_opcode          (a_drv.opcode),
        .auto_in_a_bits_param           (a_drv.param),
        .auto_in_a_bits_size            (a_drv.size),
        .auto_in_a_bits_source          (a_drv.source),
        .auto_in_a_bits_address         (a_drv.address),
        .auto_in_a_bits_mask            (a_drv.mask),
        .auto_in_a_bits_data            (a_drv.data),
        .auto_in_a_bits_corrupt         (a_drv.corrupt),
        .auto_in_d_valid                (d_valid),
        .auto_in_d_ready                (d_ready),
        .auto_in_d_bits_opcode          (d_opcode),
        .auto_in_d_bits_param           (d_param),
        .auto_in_d_bits_size            (d_size),
        .auto_in_d_bits_source          (d_source),
        .auto_in_d_bits_sink            (d_sink),
        .auto_in_d_bits_denied          (d_denied),
        .auto_in_d_bits_data            (d_data),
        .auto_in_d_bits_corrupt         (d_corrupt),
        .auto_out_a_mem_0_opcode        (m_opcode),
        .auto_out_a_mem_0_param         (m_param),
        .auto_out_a_mem_0_size          (m_size),
        .auto_out_a_mem_0_source        (m_source),
        .auto_out_a_mem_0_address       (m_address),
        .auto_out_a_mem_0_mask          (m_mask),
        .auto_out_a_mem_0_data          (m_data),
        .auto_out_a_mem_0_corrupt       (m_corrupt),
        .auto_out_a_widx                (a_widx),
        .auto_out_a_safe_widx_valid     (a_safe_widx_valid),
        .auto_out_a_safe_source_reset_n (a_safe_source_reset_n),
        .auto_out_a_ridx                (a_ridx),
        .auto_out_a_safe_ridx_valid     (a_safe_ridx_valid),
        .auto_out_a_safe_sink_reset_n   (a_safe_sink_reset_n),
        .auto_out_d_mem_0_opcode        (d_rem.opcode),
        .auto_out_d_mem_0_param         (d_rem.param),
        .auto_out_d_mem_0_size          (d_rem.size),
        .auto_out_d_mem_0_source        (d_rem.source),
        .auto_out_d_mem_0_sink          (d_rem.sink),
        .auto_out_d_mem_0_denied        (d_rem.denied),
        .auto_out_d_mem_0_data          (d_rem.data),
        .auto_out_d_mem_0_corrupt       (d_rem.corrupt),
        .auto_out_d_widx                (d_widx),
        .auto_out_d_safe_widx_valid     (d_safe_widx_valid),
        .auto_out_d_safe_source_reset_n (d_safe_source_reset_n),
        .auto_out_d_ridx                (d_ridx),
        .auto_out_d_safe_ridx_valid     (d_safe_ridx_valid),
        .auto_out_d_safe_sink_reset_n   (d_safe_sink_reset_n)
    );

    assign a_obs = '{m_opcode, m_param, m_size, m_source, m_address, m_mask, m_data, m_corrupt};
    assign d_obs = '{d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        beat1  = '{3'd4, 3'd0, 2'd2, 1'b0, 9'h1A4, 4'hF, 32'hDEADBEEF, 1'b0};
        beat2  = '{3'd0, 3'd0, 2'd1, 1'b1, 9'h0C8, 4'h3, 32'hA5A55A5A, 1'b0};
        beat3  = '{3'd1, 3'd0, 2'd0, 1'b0, 9'h003, 4'h8, 32'h11223344, 1'b0};
        beat4  = '{3'd4, 3'd0, 2'd2, 1'b1, 9'h1FC, 4'hF, 32'h0BADF00D, 1'b0};
        dbeat1 = '{3'd1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0};
        dbeat2 = '{3'd1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1};
        dbeat3 = '{3'd1, 2'd1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h55AA33CC, 1'b0};

        reset = 1'b0;
        a_valid = 1'b0; a_drv = '0; d_ready = 1'b0;
        a_ridx = 1'b0; a_safe_ridx_valid = 1'b0; a_safe_sink_reset_n = 1'b0;
        d_rem = '0; d_widx = 1'b0; d_safe_widx_valid = 1'b0; d_safe_source_reset_n = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_a_widx", a_widx, 0);
        chk("rst_d_ridx", d_ridx, 0);
        chk("rst_alive_flags", {a_safe_widx_valid, a_safe_source_reset_n,
                                d_safe_ridx_valid, d_safe_sink_reset_n}, 0);
        chk("rst_a_mem", a_obs, 0);
        chk("rst_d_bits", d_obs, 0);

        reset = 1'b1;
        cyc(1);
        chk("alive_flags_up", {a_safe_widx_valid, a_safe_source_reset_n,
                               d_safe_ridx_valid, d_safe_sink_reset_n}, 4'hF);
        chk("ready_without_peer", a_ready, 0);

        // Remote sides come alive; ready after exactly SS cycles
        a_safe_ridx_valid = 1'b1; a_safe_sink_reset_n = 1'b1;
        d_safe_widx_valid = 1'b1; d_safe_source_reset_n = 1'b1;
        cyc(SS - 1);
        chk("ready_early", a_ready, 0);
        cyc(1);
        chk("ready_on_time", a_ready, 1);

        // Single A beat
        a_valid = 1'b1; a_drv = beat1;
        chk("a1_ready_at_fire", a_ready, 1);
        cyc(1);
        a_valid = 1'b0; a_drv = '0;
        chk("a1_widx", a_widx, 1);
        chk("a1_mem", a_obs, beat1);
        chk("a1_ready_low", a_ready, 0);
        cyc(2);
        chk("a1_ready_wait", a_ready, 0);
        a_ridx = 1'b1;
        cyc(SS - 1);
        chk("a1_ridx_early", a_ready, 0);
        cyc(1);
        chk("a1_ridx_return", a_ready, 1);

        // Single D beat, stalled 5 cycles
        d_rem = dbeat1; d_widx = 1'b1;
        cyc(SS);
        chk("d1_valid_early", d_valid, 0);
        cyc(1);
        chk("d1_valid", d_valid, 1);
        chk("d1_bits", d_obs, dbeat1);
        d_rem = '1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("d1_stall_valid", d_valid, 1);
            chk("d1_stall_bits", d_obs, dbeat1);
        end
        d_ready = 1'b1;
        cyc(1);
        d_ready = 1'b0;
        chk("d1_ridx", d_ridx, 1);
        chk("d1_valid_drop", d_valid, 0);
        cyc(2);
        chk("d1_valid_stays_low", d_valid, 0);

        // Simultaneous A and D fire
        d_rem = dbeat2; d_widx = 1'b0;
        cyc(SS + 1);
        chk("sim_d_valid", d_valid, 1);
        chk("sim_d_bits", d_obs, dbeat2);
        chk("sim_a_ready", a_ready, 1);
        a_valid = 1'b1; a_drv = beat2; d_ready = 1'b1;
        cyc(1);
        a_valid = 1'b0; a_drv = '0; d_ready = 1'b0;
        chk("sim_widx", a_widx, 0);
        chk("sim_ridx", d_ridx, 0);
        chk("sim_d_valid_drop", d_valid, 0);
        chk("sim_a_mem", a_obs, beat2);
        a_ridx = 1'b0;
        cyc(SS);
        chk("sim_ready_return", a_ready, 1);

        // Remote sink reset with an A beat outstanding
        a_valid = 1'b1; a_drv = beat3;
        cyc(1);
        a_valid = 1'b0; a_drv = '0;
        chk("k_widx_set", a_widx, 1);
        chk("k_mem", a_obs, beat3);
        a_safe_sink_reset_n = 1'b0;
        cyc(SS + 1);
        chk("k_widx_cleared", a_widx, 0);
        chk("k_ready_low", a_ready, 0);
        chk("k_mem_kept", a_obs, beat3);
        chk("k_alive_kept", a_safe_source_reset_n, 1);
        a_safe_sink_reset_n = 1'b1;
        cyc(SS - 1);
        chk("k_ready_early", a_ready, 0);
        cyc(1);
        chk("k_ready_back", a_ready, 1);
        a_valid = 1'b1; a_drv = beat4;
        cyc(1);
        a_valid = 1'b0; a_drv = '0;
        chk("k_fresh_widx", a_widx, 1);
        chk("k_fresh_mem", a_obs, beat4);
        chk("k_fresh_ready", a_ready, 0);

        // Local reset while D valid is pending
        d_rem = dbeat3; d_widx = 1'b1;
        cyc(SS + 1);
        chk("lr_d_valid", d_valid, 1);
        chk("lr_d_bits", d_obs, dbeat3);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        chk("lr_d_valid_drop", d_valid, 0);
        chk("lr_d_ridx", d_ridx, 0);
        chk("lr_a_widx", a_widx, 0);
        chk("lr_alive", a_safe_widx_valid, 0);
        chk("lr_d_bits_zero", d_obs, 0);
        cyc(SS);
        chk("lr_resync_wait", d_valid, 0);
        cyc(1);
        chk("lr_resync_valid", d_valid, 1);
        chk("lr_resync_bits", d_obs, dbeat3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
